// File: rtl/instruction_memory_loader.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// instruction_memory_loader
//
// Byte-serial program loader for the instruction memory write port.
// Input stream format (after a start pulse):
//   [len_lo] [len_hi] [4*N payload bytes, little-endian words] [xor byte]
// Each assembled word is written at byte address index*4. The trailing xor
// byte is the XOR of all payload bytes. It is present only when
// LOADER_CHECKSUM_EN is defined. Without that macro the load ends after the
// last payload word.
//
// Parameters
//   WordQuantity : number of 32-bit words in instruction memory
//   BitSize      : log2(WordQuantity), width of the word index
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   synchronous active-high reset
//   start      in   begins a load from IDLE/DONE/ERROR; ignored otherwise
//   rx_data    in   incoming byte
//   rx_valid   in   one byte per high cycle, no backpressure
//   mem_we     out  one-cycle write strobe
//   mem_addr   out  byte address of the write (index*4)
//   mem_wdata  out  word to write
//   busy       out  high while a load is in progress (stalls fetch)
//   done       out  sticky, load completed successfully
//   error      out  sticky, bad length or checksum mismatch
//
// Optional feature macro: LOADER_CHECKSUM_EN
// ---------------------------------------------------------------------------
module instruction_memory_loader #(
    parameter int WordQuantity = 256,
    parameter int BitSize      = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        busy,
    output logic        done,
    output logic        error
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LEN   = 3'd1,
        ST_LOAD  = 3'd2,
        ST_CHK   = 3'd3,
        ST_DONE  = 3'd4,
        ST_ERROR = 3'd5
    } state_t;

    // Word count limit, one bit wider than the 16-bit length field.
    localparam logic [16:0]      MAX_WORDS = 17'(WordQuantity);
    localparam logic [BitSize:0] IDX_ONE   = {{BitSize{1'b0}}, 1'b1};

    // Running XOR checksum of the payload bytes.
    function automatic logic [7:0] csum_next(input logic [7:0] acc, input logic [7:0] b);
        csum_next = acc ^ b;
    endfunction

    // Byte address of a word index. The index never reaches WordQuantity
    // when a write is issued, so only its low BitSize bits are needed.
    function automatic logic [31:0] word_addr(input logic [BitSize:0] idx);
        word_addr = 32'({idx[BitSize-1:0], 2'b00});
    endfunction

    state_t             state_r;
    state_t             state_s;
    logic [1:0]         byte_cnt_r;
    logic [23:0]        word_buf_r;
    logic [7:0]         len_lo_r;
    logic [15:0]        len_r;
    logic [BitSize:0]   index_r;
    logic               mem_we_r;
    logic [31:0]        mem_addr_r;
    logic [31:0]        mem_wdata_r;
    logic               busy_r;
    logic               done_r;
    logic               error_r;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]         csum_r;
`endif

    logic [15:0]        len_rx_s;
    logic               len_bad_s;
    logic               last_word_s;
    logic               start_ok_s;
    logic               word_byte_s;
    logic               busy_s;
    logic               done_s;
    logic               error_s;

    // Decode of the current byte against the stored length and index.
    always_comb begin
        len_rx_s    = {rx_data, len_lo_r};
        len_bad_s   = (len_rx_s == 16'd0) || ({1'b0, len_rx_s} > MAX_WORDS);
        // The word being completed now is the last one of the load.
        last_word_s = ((16'(index_r) + 16'd1) == len_r);
        // A start is only honoured when no load is in progress.
        if ((state_r == ST_IDLE) || (state_r == ST_DONE) || (state_r == ST_ERROR)) begin
            start_ok_s = start;
        end else begin
            start_ok_s = 1'b0;
        end
        // The fourth byte of a word has arrived in LOAD.
        if ((state_r == ST_LOAD) && rx_valid && (byte_cnt_r == 2'd3)) begin
            word_byte_s = 1'b1;
        end else begin
            word_byte_s = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start) begin
                    state_s = ST_LEN;
                end else begin
                    state_s = state_r;
                end
            end
            ST_LEN: begin
                if (rx_valid && (byte_cnt_r == 2'd1)) begin
                    if (len_bad_s) begin
                        state_s = ST_ERROR;
                    end else begin
                        state_s = ST_LOAD;
                    end
                end else begin
                    state_s = ST_LEN;
                end
            end
            ST_LOAD: begin
                if (word_byte_s && last_word_s) begin
`ifdef LOADER_CHECKSUM_EN
                    state_s = ST_CHK;
`else
                    state_s = ST_DONE;
`endif
                end else begin
                    state_s = ST_LOAD;
                end
            end
`ifdef LOADER_CHECKSUM_EN
            ST_CHK: begin
                if (rx_valid) begin
                    if (rx_data == csum_r) begin
                        state_s = ST_DONE;
                    end else begin
                        state_s = ST_ERROR;
                    end
                end else begin
                    state_s = ST_CHK;
                end
            end
`endif
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Status outputs follow the next state so they change together with it.
    always_comb begin
        busy_s  = 1'b0;
        done_s  = 1'b0;
        error_s = 1'b0;
        case (state_s)
            ST_LEN, ST_LOAD, ST_CHK: begin
                busy_s = 1'b1;
            end
            ST_DONE: begin
                done_s = 1'b1;
            end
            ST_ERROR: begin
                error_s = 1'b1;
            end
            default: begin
                busy_s  = 1'b0;
                done_s  = 1'b0;
                error_s = 1'b0;
            end
        endcase
    end

    // Registered status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            error_r <= 1'b0;
        end else begin
            busy_r  <= busy_s;
            done_r  <= done_s;
            error_r <= error_s;
        end
    end

    // Datapath: length capture, word assembly, write issue, checksum.
    always_ff @(posedge clk) begin
        if (reset) begin
            byte_cnt_r  <= 2'd0;
            word_buf_r  <= 24'd0;
            len_lo_r    <= 8'd0;
            len_r       <= 16'd0;
            index_r     <= {(BitSize+1){1'b0}};
            mem_we_r    <= 1'b0;
            mem_addr_r  <= 32'd0;
            mem_wdata_r <= 32'd0;
`ifdef LOADER_CHECKSUM_EN
            csum_r      <= 8'd0;
`endif
        end else begin
            // The write strobe is a single-cycle pulse.
            mem_we_r <= 1'b0;
            if (start_ok_s) begin
                byte_cnt_r <= 2'd0;
                index_r    <= {(BitSize+1){1'b0}};
`ifdef LOADER_CHECKSUM_EN
                csum_r     <= 8'd0;
`endif
            end else begin
                case (state_r)
                    ST_LEN: begin
                        if (rx_valid) begin
                            if (byte_cnt_r == 2'd0) begin
                                len_lo_r   <= rx_data;
                                byte_cnt_r <= 2'd1;
                            end else begin
                                len_r      <= len_rx_s;
                                byte_cnt_r <= 2'd0;
                            end
                        end
                    end
                    ST_LOAD: begin
                        if (rx_valid) begin
`ifdef LOADER_CHECKSUM_EN
                            csum_r <= csum_next(csum_r, rx_data);
`endif
                            // Two-bit counter wraps back to 0 after the 4th byte.
                            byte_cnt_r <= byte_cnt_r + 2'd1;
                            case (byte_cnt_r)
                                2'd0: word_buf_r[7:0]   <= rx_data;
                                2'd1: word_buf_r[15:8]  <= rx_data;
                                2'd2: word_buf_r[23:16] <= rx_data;
                                2'd3: begin
                                    mem_wdata_r <= {rx_data, word_buf_r};
                                    mem_addr_r  <= word_addr(index_r);
                                    mem_we_r    <= 1'b1;
                                    index_r     <= index_r + IDX_ONE;
                                end
                                default: word_buf_r <= word_buf_r;
                            endcase
                        end
                    end
                    default: begin
                        byte_cnt_r <= byte_cnt_r;
                    end
                endcase
            end
        end
    end

    assign mem_we    = mem_we_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign error     = error_r;

endmodule
